// File: rtl/ajuste_pkg.sv
// rtl/ajuste_pkg.sv - shared state encoding, field codes and limits for the time-set block
package ajuste_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SET_H = 2'b01,
      ST_SET_M = 2'b10,
      ST_LOAD  = 2'b11
   } state_t;

   localparam logic [1:0] CAMPO_NONE = 2'b00;
   localparam logic [1:0] CAMPO_HORA = 2'b01;
   localparam logic [1:0] CAMPO_MIN  = 2'b10;

   localparam int HORA_MAX = 23;
   localparam int MIN_MAX  = 59;

endpackage

// File: rtl/bcd_updown.sv
// rtl/bcd_updown.sv - two-digit BCD up/down register wrapping between 00 and MAX
module bcd_updown #(
   parameter int MAX = 59,
   parameter int TW  = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_i,
   input  logic [TW-1:0] load_tens_i,
   input  logic [3:0]    load_units_i,
   input  logic          en_i,
   input  logic          up_i,
   output logic [TW-1:0] tens_o,
   output logic [3:0]    units_o
);

   localparam logic [TW-1:0] TENS_MAX  = TW'(MAX / 10);
   localparam logic [3:0]    UNITS_MAX = 4'(MAX % 10);

   logic [TW-1:0] tens_q, tens_d;
   logic [3:0]    units_q, units_d;

   always_comb begin
      tens_d  = tens_q;
      units_d = units_q;
      if (load_i) begin
         tens_d  = load_tens_i;
         units_d = load_units_i;
      end else if (en_i) begin
         if (up_i) begin
            if (tens_q == TENS_MAX && units_q == UNITS_MAX) begin
               tens_d  = '0;
               units_d = 4'd0;
            end else if (units_q == 4'd9) begin
               tens_d  = tens_q + TW'(1);
               units_d = 4'd0;
            end else begin
               units_d = units_q + 4'd1;
            end
         end else begin
            // Borrow from 00 wraps to MAX, so the hour tens never see 2 with units above 3
            if (tens_q == '0 && units_q == 4'd0) begin
               tens_d  = TENS_MAX;
               units_d = UNITS_MAX;
            end else if (units_q == 4'd0) begin
               tens_d  = tens_q - TW'(1);
               units_d = 4'd9;
            end else begin
               units_d = units_q - 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tens_q  <= '0;
         units_q <= 4'd0;
      end else begin
         tens_q  <= tens_d;
         units_q <= units_d;
      end
   end

   assign tens_o  = tens_q;
   assign units_o = units_q;

endmodule

// File: rtl/ajuste_hora.sv
// rtl/ajuste_hora.sv - button-driven HH:MM edit FSM with timeout and one-cycle load strobe
module ajuste_hora
   import ajuste_pkg::*;
#(
   parameter int TIMEOUT = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_dec,
   output logic [1:0] H_in1,
   output logic [3:0] H_in0,
   output logic [3:0] M_in1,
   output logic [3:0] M_in0,
   output logic       LD_time,
   output logic       editing,
   output logic [1:0] campo
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] to_q, to_d;
   logic          mode_prev_q, inc_prev_q, dec_prev_q;
   logic          ld_q, ld_d;
   logic          editing_q, editing_d;
   logic [1:0]    campo_q, campo_d;
   logic [1:0]    com_h1_q;
   logic [3:0]    com_h0_q, com_m1_q, com_m0_q;

   logic mode_e, inc_e, dec_e, any_e;
   logic h_en, m_en, revert;

   logic [1:0] wh1;
   logic [3:0] wh0, wm1, wm0;

   // Previous samples start at 1 so a button held through reset release is not an edge
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_prev_q <= 1'b1;
         inc_prev_q  <= 1'b1;
         dec_prev_q  <= 1'b1;
      end else begin
         mode_prev_q <= btn_mode;
         inc_prev_q  <= btn_inc;
         dec_prev_q  <= btn_dec;
      end
   end

   assign mode_e = btn_mode & ~mode_prev_q;
   assign inc_e  = btn_inc  & ~inc_prev_q;
   assign dec_e  = btn_dec  & ~dec_prev_q;
   assign any_e  = mode_e | inc_e | dec_e;

   always_comb begin
      state_d = state_q;
      to_d    = to_q;
      h_en    = 1'b0;
      m_en    = 1'b0;
      revert  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            to_d = '0;
            if (mode_e) state_d = ST_SET_H;
         end
         ST_SET_H, ST_SET_M: begin
            if (mode_e) begin
               to_d    = '0;
               state_d = (state_q == ST_SET_H) ? ST_SET_M : ST_LOAD;
            end else if (any_e) begin
               to_d = '0;
               // Simultaneous inc and dec cancel out
               if (state_q == ST_SET_H) h_en = inc_e ^ dec_e;
               else                     m_en = inc_e ^ dec_e;
            end else if (to_q == TO_LAST) begin
               to_d    = '0;
               revert  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               to_d = to_q + CW'(1);
            end
         end
         ST_LOAD: begin
            to_d    = '0;
            state_d = ST_IDLE;
         end
         default: begin
            to_d    = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      ld_d      = (state_d == ST_LOAD);
      editing_d = (state_d == ST_SET_H) || (state_d == ST_SET_M);
      campo_d   = CAMPO_NONE;
      if (state_d == ST_SET_H)      campo_d = CAMPO_HORA;
      else if (state_d == ST_SET_M) campo_d = CAMPO_MIN;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         to_q      <= '0;
         ld_q      <= 1'b0;
         editing_q <= 1'b0;
         campo_q   <= CAMPO_NONE;
      end else begin
         state_q   <= state_d;
         to_q      <= to_d;
         ld_q      <= ld_d;
         editing_q <= editing_d;
         campo_q   <= campo_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         com_h1_q <= 2'd0;
         com_h0_q <= 4'd0;
         com_m1_q <= 4'd0;
         com_m0_q <= 4'd0;
      end else if (state_q == ST_LOAD) begin
         com_h1_q <= wh1;
         com_h0_q <= wh0;
         com_m1_q <= wm1;
         com_m0_q <= wm0;
      end
   end

   bcd_updown #(.MAX(HORA_MAX), .TW(2)) u_horas (
      .clk          (clk),
      .reset        (reset),
      .load_i       (revert),
      .load_tens_i  (com_h1_q),
      .load_units_i (com_h0_q),
      .en_i         (h_en),
      .up_i         (inc_e),
      .tens_o       (wh1),
      .units_o      (wh0)
   );

   bcd_updown #(.MAX(MIN_MAX), .TW(4)) u_minutos (
      .clk          (clk),
      .reset        (reset),
      .load_i       (revert),
      .load_tens_i  (com_m1_q),
      .load_units_i (com_m0_q),
      .en_i         (m_en),
      .up_i         (inc_e),
      .tens_o       (wm1),
      .units_o      (wm0)
   );

   assign H_in1   = wh1;
   assign H_in0   = wh0;
   assign M_in1   = wm1;
   assign M_in0   = wm0;
   assign LD_time = ld_q;
   assign editing = editing_q;
   assign campo   = campo_q;

endmodule

// File: tb/tb_ajuste_hora.sv
// tb/tb_ajuste_hora.sv - directed scoreboard bench for the time-set block
module tb_ajuste_hora;

   localparam int B_MODE = 1;
   localparam int B_INC  = 2;
   localparam int B_DEC  = 4;

   logic clk, reset, btn_mode, btn_inc, btn_dec;

   logic [1:0] a_h1, b_h1;
   logic [3:0] a_h0, a_m1, a_m0, b_h0, b_m1, b_m0;
   logic       a_ld, a_ed, b_ld, b_ed;
   logic [1:0] a_campo, b_campo;

   int total, bad;
   int ld_cnt, ld_cnt2, l0;
   logic [31:0] exp_q[$];

   ajuste_hora dut (
      .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
      .H_in1(a_h1), .H_in0(a_h0), .M_in1(a_m1), .M_in0(a_m0),
      .LD_time(a_ld), .editing(a_ed), .campo(a_campo)
   );

   ajuste_hora #(.TIMEOUT(8)) dut_to (
      .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
      .H_in1(b_h1), .H_in0(b_h0), .M_in1(b_m1), .M_in0(b_m0),
      .LD_time(b_ld), .editing(b_ed), .campo(b_campo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      ld_cnt  = 0;
      ld_cnt2 = 0;
   end
   always @(negedge clk) begin
      if (a_ld === 1'b1) ld_cnt  = ld_cnt + 1;
      if (b_ld === 1'b1) ld_cnt2 = ld_cnt2 + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] pack(input int h, input int m);
      logic [1:0] t;
      t = 2'(h / 10);
      return {18'd0, t, 4'(h % 10), 4'(m / 10), 4'(m % 10)};
   endfunction

   function automatic logic [31:0] obs_a();
      return {18'd0, a_h1, a_h0, a_m1, a_m0};
   endfunction

   function automatic logic [31:0] obs_b();
      return {18'd0, b_h1, b_h0, b_m1, b_m0};
   endfunction

   task automatic push(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] ex;
      total = total + 1;
      if (exp_q.size() == 0) begin
         bad = bad + 1;
         $error("FAIL %s: observed %0h, scoreboard empty", tag, obs);
      end else begin
         ex = exp_q.pop_front();
         assert (obs === ex) else begin
            bad = bad + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, ex);
         end
      end
   endtask

   task automatic press(input int which);
      @(negedge clk);
      btn_mode = (which & B_MODE) != 0;
      btn_inc  = (which & B_INC)  != 0;
      btn_dec  = (which & B_DEC)  != 0;
      @(negedge clk);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      btn_dec  = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      btn_dec  = 1'b0;
      repeat (3) @(negedge clk);
      push(pack(0, 0)); chk("rst_value", obs_a());
      push(32'd0);      chk("rst_edit_campo", {29'd0, a_ed, a_campo});
      push(32'd0);      chk("rst_ld", {31'd0, a_ld});
      push(pack(0, 0)); chk("rst_value_to", obs_b());
      reset = 1'b0;
      @(negedge clk);

      // Basic edit and commit to 13:59
      push(32'b101); press(B_MODE); chk("enter_set_h", {29'd0, a_ed, a_campo});
      push(pack(13, 0));
      repeat (13) press(B_INC);
      chk("hours_13", obs_a());
      push(32'b110); press(B_MODE); chk("enter_set_m", {29'd0, a_ed, a_campo});
      push(pack(13, 59)); press(B_DEC); chk("min_dec_wrap", obs_a());
      l0 = ld_cnt;
      push(32'd1); press(B_MODE); chk("ld_one_cycle", 32'(ld_cnt - l0));
      push(pack(13, 59)); chk("commit_1359", obs_a());
      push(32'd0); chk("idle_after_load", {29'd0, a_ed, a_campo});
      push(pack(13, 59)); press(B_INC); chk("idle_inc_ignored", obs_a());
      push(32'd0); chk("idle_still", {31'd0, a_ed});

      // Hour and minute wraps
      press(B_MODE);
      repeat (10) press(B_INC);
      push(pack(23, 59)); chk("hours_23", obs_a());
      push(pack(0, 59));  press(B_INC); chk("hour_wrap_up", obs_a());
      push(pack(23, 59)); press(B_DEC); chk("hour_wrap_down", obs_a());
      press(B_MODE);
      push(pack(23, 0)); press(B_INC); chk("min_wrap_no_carry", obs_a());
      press(B_MODE);

      // Simultaneous buttons
      press(B_MODE);
      push(pack(23, 0)); press(B_INC | B_DEC); chk("inc_dec_cancel", obs_a());
      push(32'b110); press(B_MODE | B_INC); chk("mode_wins_campo", {29'd0, a_ed, a_campo});
      push(pack(23, 0)); chk("mode_wins_value", obs_a());

      // Held inc gives a single step
      push(pack(23, 1));
      @(negedge clk);
      btn_inc = 1'b1;
      repeat (20) @(negedge clk);
      btn_inc = 1'b0;
      @(negedge clk);
      chk("held_inc_once", obs_a());
      press(B_MODE);

      // Buttons held through reset release do nothing
      @(negedge clk);
      reset = 1'b1; btn_inc = 1'b1; btn_mode = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      push(32'd0); chk("held_mode_rst", {31'd0, a_ed});
      push(pack(0, 0)); chk("held_inc_rst", obs_a());
      btn_inc = 1'b0; btn_mode = 1'b0;
      @(negedge clk);
      push(32'b101); press(B_MODE); chk("enter_after_rst", {29'd0, a_ed, a_campo});
      push(pack(0, 0)); chk("no_inc_after_rst", obs_a());

      // Reset on the cycle that would enter LOAD
      press(B_MODE);
      repeat (2) press(B_INC);
      push(pack(0, 2)); chk("pre_abort_value", obs_a());
      l0 = ld_cnt;
      @(negedge clk);
      btn_mode = 1'b1; reset = 1'b1;
      @(negedge clk);
      btn_mode = 1'b0; reset = 1'b0;
      repeat (3) @(negedge clk);
      push(32'd0); chk("abort_no_ld", 32'(ld_cnt - l0));
      push(pack(0, 0)); chk("abort_value", obs_a());
      push(32'd0); chk("abort_edit", {29'd0, a_ed, a_campo});

      // Timeout on the TIMEOUT=8 instance
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      press(B_MODE);
      repeat (10) press(B_INC);
      press(B_MODE);
      repeat (30) press(B_INC);
      press(B_MODE);
      push(pack(10, 30)); chk("to_commit", obs_b());
      l0 = ld_cnt2;
      press(B_MODE);
      repeat (2) press(B_INC);
      push(pack(12, 30)); chk("to_edit_12", obs_b());
      push(32'b101); chk("to_editing", {29'd0, b_ed, b_campo});
      repeat (3) @(negedge clk);
      push(32'd1); chk("to_not_yet", {31'd0, b_ed});
      repeat (10) @(negedge clk);
      push(32'd0); chk("to_expired", {29'd0, b_ed, b_campo});
      push(pack(10, 30)); chk("to_revert", obs_b());
      push(32'd0); chk("to_no_ld", 32'(ld_cnt2 - l0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ajuste_hora.md
AJUSTE_HORA -- requirements
Module: ajuste_hora

Interface
REQ-001 Parameter TIMEOUT, default 60: number of clk cycles without any button edge, while editing, before the edit is aborted.
REQ-002 clk  input  1  single system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 btn_mode  input  1  level button; a rising edge advances the edit field.
REQ-005 btn_inc  input  1  level button; a rising edge increments the field being edited.
REQ-006 btn_dec  input  1  level button; a rising edge decrements the field being edited.
REQ-007 H_in1  output  2  BCD hour tens (0..2), drives the clock load port.
REQ-008 H_in0  output  4  BCD hour units (0..9).
REQ-009 M_in1  output  4  BCD minute tens (0..5).
REQ-010 M_in0  output  4  BCD minute units (0..9).
REQ-011 LD_time  output  1  one-cycle load strobe to the clock.
REQ-012 editing  output  1  high while in SET_H or SET_M.
REQ-013 campo  output  2  field being edited: 00 none, 01 hours, 10 minutes.

Function
REQ-014 Each button SHALL be edge-detected with a registered previous sample: an edge is btn=1 while prev=0; a held button SHALL produce only one action.
REQ-015 An action SHALL be applied on the clk edge that samples the button edge; outputs SHALL show the result on the next cycle.
REQ-016 FSM states SHALL be IDLE, SET_H, SET_M and LOAD.
REQ-017 IDLE: a btn_mode edge SHALL go to SET_H; inc/dec edges SHALL be ignored.
REQ-018 SET_H: inc SHALL step hours 00..23 and wrap 23->00; dec SHALL wrap 00->23; a btn_mode edge SHALL go to SET_M.
REQ-019 SET_M: inc SHALL step 00..59 and wrap 59->00; dec SHALL wrap 00->59; a btn_mode edge SHALL go to LOAD.
REQ-020 LOAD SHALL last one cycle, with LD_time=1 in that cycle only; it SHALL copy the working value into the committed registers and return to IDLE.
REQ-021 Counting SHALL be done directly in BCD: units carry/borrow into tens; H_in0 SHALL never exceed 3 when H_in1=2; no binary-to-BCD conversion.
REQ-022 Simultaneous inc and dec edges SHALL leave the value unchanged; a mode edge together with inc/dec SHALL apply mode only.
REQ-023 The timeout counter SHALL clear on any button edge and count in SET_H/SET_M; when it reaches TIMEOUT, the FSM SHALL go to IDLE, no LD_time, and the working value SHALL revert to the committed value.
REQ-024 The outputs SHALL always show the working value; in IDLE this equals the committed value.
REQ-025 editing and campo SHALL be registered and SHALL change in the same cycle as the state.

Reset
REQ-026 On reset: state IDLE, working and committed values 00:00, LD_time 0, editing 0, campo 00, timeout counter 0.
REQ-027 On reset, the button previous-sample registers SHALL be set to 1, so a button held through reset release SHALL not act.
REQ-028 A reset during SET_H, SET_M or LOAD SHALL abort with no LD_time pulse in the following cycle.

Structure
REQ-029 Package ajuste_pkg SHALL hold:
- the state encoding;
- the campo codes;
- constants HORA_MAX=23 and MIN_MAX=59.
REQ-030 Sub-module bcd_updown SHALL be a two-digit BCD up/down register with a max-value parameter, wrap both ways, load and enable inputs; it SHALL be instantiated once for hours and once for minutes.
REQ-031 The FSM, edge detectors, timeout counter and committed registers SHALL live in ajuste_hora.

Verification
REQ-032 After reset: mode, inc x13, mode, dec x1, mode -> LD_time exactly 1 cycle; outputs 13:59; then editing=0.
REQ-033 Hour wrap: from 23 press inc -> 00; press dec -> 23; minute 59 inc -> 00 with no hour carry.
REQ-034 Held button: btn_inc high 20 cycles in SET_M -> minutes +1 only; btn_inc held across reset release -> no change.
REQ-035 Timeout (TIMEOUT=8): commit 10:30, enter SET_H, inc x2 -> 12, idle 8 cycles -> IDLE, outputs 10:30, no LD_time.
REQ-036 Simultaneous inc+dec in SET_H -> unchanged; mode+inc in SET_H -> campo=10, hours unchanged.
REQ-037 Reset asserted in the cycle LOAD would begin -> LD_time stays 0; outputs 00:00.
